// File: rtl/rowo_mult.sv
// Tap-fetch RAM (narrow 16-bit write, wide L-lane read) feeding per-lane signed 16x16 multipliers.
// Read latency 2, multiply latency 2; fully pipelined, no stall or handshake.
module rowo_mult #(
  parameter  int RDW = 32,
  parameter  int RAW = 8,
  localparam int L   = RDW / 16,
  localparam int WAW = RAW + $clog2(L)
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               wren,
  input  logic [WAW-1:0]     wraddress,
  input  logic [15:0]        data,
  input  logic               rden,
  input  logic [RAW-1:0]     rdaddress,
  output logic [RDW-1:0]     q,
  input  logic [RDW-1:0]     coef,
  output logic [2*RDW-1:0]   result
);

  logic [15:0] mem [2**WAW];

  logic [RAW-1:0]        rd_addr_q;
  logic [RDW-1:0]        q_d, q_q;
  logic [L-1:0][15:0]    a_q, b_q;
  logic [L-1:0][31:0]    res_d, res_q;

  // Sample storage is not reset; contents are undefined until written.
  always_ff @(posedge clock) begin
    if (wren) mem[wraddress] <= data;
  end

  // Lane k of wide word A is sample L*A+k, so the lower lane holds the lower address.
  always_comb begin
    q_d = '0;
    for (int k = 0; k < L; k++) begin
      q_d[16*k +: 16] = mem[WAW'(L * int'(rd_addr_q) + k)];
    end
  end

  always_comb begin
    res_d = '0;
    for (int k = 0; k < L; k++) begin
      res_d[k] = 32'($signed(a_q[k])) * 32'($signed(b_q[k]));
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
      q_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
    end else begin
      if (rden) rd_addr_q <= rdaddress;
      // q reloads every cycle, so a held address tracks later writes to that word.
      q_q   <= q_d;
      a_q   <= q_q;
      b_q   <= coef;
      res_q <= res_d;
    end
  end

  assign q      = q_q;
  assign result = res_q;

endmodule

// File: tb/tb_rowo_mult.sv
// Scoreboard bench for rowo_mult: a sample-array model predicts q and per-lane products per cycle.
module tb_rowo_mult;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        wren = 1'b0;
  logic [8:0]  wraddress = '0;
  logic [15:0] data = '0;
  logic        rden = 1'b0;
  logic [7:0]  rdaddress = '0;
  logic [31:0] coef = '0;
  logic [31:0] q;
  logic [63:0] result;

  always #5 clock = ~clock;

  rowo_mult #(.RDW(32), .RAW(8)) dut (
    .clock(clock), .rst_n(rst_n), .wren(wren), .wraddress(wraddress), .data(data),
    .rden(rden), .rdaddress(rdaddress), .q(q), .coef(coef), .result(result)
  );

  typedef struct {
    int          cyc;
    logic [63:0] v;
    bit          chk;
  } exp_t;

  exp_t        qexp[$];
  exp_t        rexp[$];
  logic [15:0] mm [512];
  bit          mk [512];
  logic [31:0] hq [4096];
  bit          hqk [4096];
  int          held_addr = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] word(input int a);
    return {mm[(2*a+1) & 511], mm[(2*a) & 511]};
  endfunction

  function automatic bit wknown(input int a);
    return mk[(2*a+1) & 511] && mk[(2*a) & 511];
  endfunction

  // Per-lane full signed products by plain integer arithmetic.
  function automatic logic [63:0] prod(input logic [31:0] x, input logic [31:0] c);
    int p0, p1;
    p0 = int'($signed(x[15:0]))  * int'($signed(c[15:0]));
    p1 = int'($signed(x[31:16])) * int'($signed(c[31:16]));
    return {p1, p0};
  endfunction

  function automatic logic [31:0] rc();
    return $urandom();
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cyc %0d got %h want %h", nm, cyc, act, exp_v);
    end
  endtask

  // One clock of stimulus. Inputs change 1 time unit after the edge and are
  // sampled at the next edge; a reset request asserts rst_n mid-cycle.
  task automatic step(input bit rst, input bit we, input int wa, input logic [15:0] wd,
                      input bit re, input int ra, input logic [31:0] cf);
    int t;
    @(posedge clock);
    #1;
    t = cyc;
    if (rst) begin
      if (rst_n) begin
        rst_n = 1'b0;
        qexp.delete();
        rexp.delete();
      end
      held_addr = 0;
      hq[t]  = '0;
      hqk[t] = 1'b1;
    end else if (!rst_n) begin
      rst_n = 1'b1;
      held_addr = 0;
      hq[t]    = '0;
      hqk[t]   = 1'b1;
      hq[t+1]  = word(0);
      hqk[t+1] = wknown(0);
      qexp.push_back('{t, 64'(0), 1'b1});
      rexp.push_back('{t, 64'(0), 1'b1});
      qexp.push_back('{t+1, 64'(hq[t+1]), hqk[t+1]});
      rexp.push_back('{t+1, 64'(0), 1'b1});
    end
    wren      = we;
    wraddress = 9'(wa);
    data      = wd;
    rden      = re;
    rdaddress = 8'(ra);
    coef      = cf;
    if (we) begin
      mm[wa & 511] = wd;
      mk[wa & 511] = 1'b1;
    end
    if (!rst) begin
      if (re) held_addr = ra & 255;
      hq[t+2]  = word(held_addr);
      hqk[t+2] = wknown(held_addr);
      qexp.push_back('{t+2, 64'(hq[t+2]), hqk[t+2]});
      rexp.push_back('{t+2, prod(hq[t], cf), hqk[t]});
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!rst_n) begin
      cmp("reset_q", 64'(q), 64'(0));
      cmp("reset_result", result, 64'(0));
    end else begin
      while (qexp.size() > 0 && qexp[0].cyc < cyc) begin
        e = qexp.pop_front();
        cmp("q_sched", 64'(e.cyc), 64'(cyc));
      end
      if (qexp.size() > 0 && qexp[0].cyc == cyc) begin
        e = qexp.pop_front();
        if (e.chk) cmp("q", 64'(q), e.v);
      end
      while (rexp.size() > 0 && rexp[0].cyc < cyc) begin
        e = rexp.pop_front();
        cmp("result_sched", 64'(e.cyc), 64'(cyc));
      end
      if (rexp.size() > 0 && rexp[0].cyc == cyc) begin
        e = rexp.pop_front();
        if (e.chk) cmp("result", result, e.v);
      end
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) begin
      mm[i] = '0;
      mk[i] = 1'b0;
    end
    for (int i = 0; i < 4096; i++) begin
      hq[i]  = '0;
      hqk[i] = 1'b0;
    end

    // Reset held with random inputs; writes still land in the array.
    for (int i = 0; i < 5; i++)
      step(1'b1, bit'($urandom % 2), int'($urandom % 512), 16'($urandom),
           bit'($urandom % 2), int'($urandom % 256), rc());

    // Mapping and signed multiply: words 0 and 1, coef aligned two cycles after read 1.
    step(1'b0, 1'b1, 0, 16'h1111, 1'b0, 0, rc());
    step(1'b0, 1'b1, 1, 16'h2222, 1'b0, 0, rc());
    step(1'b0, 1'b1, 2, 16'hFFFE, 1'b0, 0, rc());
    step(1'b0, 1'b1, 3, 16'h8000, 1'b0, 0, rc());
    step(1'b0, 1'b0, 0, 16'h0, 1'b1, 0, rc());
    step(1'b0, 1'b0, 0, 16'h0, 1'b1, 1, rc());
    step(1'b0, 1'b0, 0, 16'h0, 1'b0, 0, rc());
    step(1'b0, 1'b0, 0, 16'h0, 1'b0, 0, 32'h8000_0003);
    step(1'b0, 1'b0, 0, 16'h0, 1'b0, 0, rc());
    step(1'b0, 1'b0, 0, 16'h0, 1'b0, 0, rc());

    // Ramp fill, then a back-to-back sweep of every wide word.
    for (int a = 0; a < 512; a++)
      step(1'b0, 1'b1, a, 16'(a), 1'b0, 0, rc());
    for (int a = 0; a < 256; a++)
      step(1'b0, 1'b0, 0, 16'h0, 1'b1, a, 32'h0001_0001);
    step(1'b0, 1'b0, 0, 16'h0, 1'b0, 0, 32'h0001_0001);
    step(1'b0, 1'b0, 0, 16'h0, 1'b0, 0, 32'h0001_0001);

    // Read-during-write on word 5 lane 0, then an immediate re-read.
    step(1'b0, 1'b1, 10, 16'h0AAA, 1'b0, 0, rc());
    step(1'b0, 1'b0, 0, 16'h0, 1'b1, 5, rc());
    step(1'b0, 1'b1, 10, 16'h0BBB, 1'b1, 5, rc());
    step(1'b0, 1'b0, 0, 16'h0, 1'b0, 0, rc());
    step(1'b0, 1'b0, 0, 16'h0, 1'b0, 0, rc());

    // rden low: address changes must be ignored and q keeps word 77.
    step(1'b0, 1'b0, 0, 16'h0, 1'b1, 77, rc());
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 0, 16'h0, 1'b0, int'($urandom % 256), rc());

    // Random traffic with a reset pulse mid-stream.
    for (int i = 0; i < 300; i++) begin
      if (i == 150)
        for (int j = 0; j < 3; j++)
          step(1'b1, bit'($urandom % 2), int'($urandom % 512), 16'($urandom),
               bit'($urandom % 2), int'($urandom % 256), rc());
      step(1'b0, bit'($urandom % 2), int'($urandom % 512), 16'($urandom),
           bit'(($urandom % 4) != 0), int'($urandom % 256), rc());
    end
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 0, 16'h0, 1'b0, 0, rc());

    repeat (3) @(posedge clock);
    #6;
    cmp("q_drain", 64'(qexp.size()), 64'(0));
    cmp("result_drain", 64'(rexp.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
